// File: rtl/reg_bank_mp.sv
// reg_bank_mp: parametrised multi-ported integer register bank.
//   DEPTH x WIDTH registers with register 0 hard-wired to zero,
//   two write ports (port 1 wins on address collision),
//   RD_PORTS combinational read ports with optional write-to-read bypass,
//   and a per-register busy scoreboard for RAW hazard detection.
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   w_en0/w_reg0/w_data0        write port 0
//   w_en1/w_reg1/w_data1        write port 1 (priority)
//   r_reg, read_data, r_busy    packed read ports: address, data, busy flag
//   busy_set_en, busy_set_reg   mark a destination register busy
//   w_collide                   previous cycle wrote the same register on both ports
module reg_bank_mp #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADD_WIDTH = 5,
  parameter int unsigned RD_PORTS  = 2,
  parameter int unsigned BYPASS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_en0,
  input  logic [ADD_WIDTH-1:0]          w_reg0,
  input  logic [WIDTH-1:0]              w_data0,
  input  logic                          w_en1,
  input  logic [ADD_WIDTH-1:0]          w_reg1,
  input  logic [WIDTH-1:0]              w_data1,
  input  logic [RD_PORTS*ADD_WIDTH-1:0] r_reg,
  output logic [RD_PORTS*WIDTH-1:0]     read_data,
  output logic [RD_PORTS-1:0]           r_busy,
  input  logic                          busy_set_en,
  input  logic [ADD_WIDTH-1:0]          busy_set_reg,
  output logic                          w_collide
);

  localparam logic [ADD_WIDTH:0] DEPTH_W = (ADD_WIDTH+1)'(DEPTH);

  // Register 0 has no storage; it reads as zero.
  logic [WIDTH-1:0]   regs_q [1:DEPTH-1];
  logic [DEPTH-1:1]   busy_q;
  logic [DEPTH-1:1]   busy_d;
  logic               w_collide_q;
  logic               w_collide_d;
  logic               we0;
  logic               we1;
  logic [ADD_WIDTH-1:0] rd_addr;

  // Effective write strobes: non-zero, in-range, and not during reset
  // (writes presented under reset are lost and must not be forwarded).
  assign we0 = w_en0 && !rst && (w_reg0 != '0) && ({1'b0, w_reg0} < DEPTH_W);
  assign we1 = w_en1 && !rst && (w_reg1 != '0) && ({1'b0, w_reg1} < DEPTH_W);

  assign w_collide_d = we0 && we1 && (w_reg0 == w_reg1);

  // Scoreboard: writes clear, busy_set sets; set is applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 1; r < DEPTH; r++) begin
      if ((we0 && (w_reg0 == ADD_WIDTH'(r))) || (we1 && (w_reg1 == ADD_WIDTH'(r))))
        busy_d[r] = 1'b0;
      if (busy_set_en && (busy_set_reg == ADD_WIDTH'(r)))
        busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 1; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      busy_q      <= '0;
      w_collide_q <= 1'b0;
    end else begin
      for (int unsigned r = 1; r < DEPTH; r++) begin
        if (we1 && (w_reg1 == ADD_WIDTH'(r)))
          regs_q[r] <= w_data1;
        else if (we0 && (w_reg0 == ADD_WIDTH'(r)))
          regs_q[r] <= w_data0;
      end
      busy_q      <= busy_d;
      w_collide_q <= w_collide_d;
    end
  end

  assign w_collide = w_collide_q;

  // Reads decode only registers 1..DEPTH-1, so register 0 and
  // out-of-range addresses fall through to the zero default.
  always_comb begin
    read_data = '0;
    r_busy    = '0;
    rd_addr   = '0;
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      rd_addr = r_reg[p*ADD_WIDTH +: ADD_WIDTH];
      for (int unsigned r = 1; r < DEPTH; r++) begin
        if (rd_addr == ADD_WIDTH'(r)) begin
          read_data[p*WIDTH +: WIDTH] = regs_q[r];
          r_busy[p]                   = busy_q[r];
          if (BYPASS != 0) begin
            if (we1 && (w_reg1 == rd_addr)) begin
              read_data[p*WIDTH +: WIDTH] = w_data1;
              r_busy[p]                   = 1'b0;
            end else if (we0 && (w_reg0 == rd_addr)) begin
              read_data[p*WIDTH +: WIDTH] = w_data0;
              r_busy[p]                   = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule
